// File: rtl/ppi_frame_receiver.sv
// PPI frame grabber: registers the parallel pixel interface, captures one armed
// frame into a dual-port pixel buffer and reports pixel/line/fs3 counts and a checksum.
module ppi_frame_receiver #(
    parameter int ADDR_BITS = 10,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [15:0]          ppi_data_i,
    input  logic                 ppi_fs1_i,
    input  logic                 ppi_fs2_i,
    input  logic                 ppi_fs3_i,
    input  logic                 arm_i,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic [CNT_BITS-1:0]  pixel_count_o,
    output logic [CNT_BITS-1:0]  line_count_o,
    output logic [7:0]           fs3_count_o,
    output logic [15:0]          checksum_o,
    output logic                 overflow_o,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [15:0]          rd_data_o
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [CNT_BITS-1:0]  CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0]  CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [ADDR_BITS:0]   PTR_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                state_r, state_next_s;
    logic [15:0]           data_r;
    logic                  fs1_r, fs2_r, fs3_r;
    logic                  fs1_d_r, fs2_d_r, fs3_d_r;
    logic                  fs1_rise_s, fs2_rise_s, fs2_fall_s, fs3_rise_s;
    logic                  active_s, sample_s, line_inc_s, fs3_inc_s, wr_en_s, full_s;
    logic                  arm_accept_s, busy_s, done_s;
    logic                  busy_r, frame_done_r, overflow_r;
    logic [CNT_BITS-1:0]   pixel_count_r, line_count_r;
    logic [7:0]            fs3_count_r;
    logic [15:0]           checksum_r;
    logic [ADDR_BITS:0]    wr_ptr_r;
    logic [15:0]           mem_r [DEPTH];
    logic [15:0]           rd_data_r;

    assign fs1_rise_s   = fs1_r & ~fs1_d_r;
    assign fs2_rise_s   = fs2_r & ~fs2_d_r;
    assign fs2_fall_s   = ~fs2_r & fs2_d_r;
    assign fs3_rise_s   = fs3_r & ~fs3_d_r;
    assign full_s       = wr_ptr_r[ADDR_BITS];
    assign arm_accept_s = (state_r == ST_IDLE) & arm_i;
    // The frame-start cycle itself is live so a pixel coincident with fs2 rising is kept.
    assign active_s     = (state_r == ST_CAPTURE) | ((state_r == ST_ARMED) & fs2_rise_s);
    assign sample_s     = active_s & fs2_r & fs1_r;
    assign line_inc_s   = active_s & fs2_r & fs1_rise_s;
    assign fs3_inc_s    = active_s & fs2_r & fs3_rise_s;
    assign wr_en_s      = sample_s & ~full_s;

    // Input capture registers and their one-cycle-delayed copies for edge detection.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_r  <= 16'd0;
            fs1_r   <= 1'b0;
            fs2_r   <= 1'b0;
            fs3_r   <= 1'b0;
            fs1_d_r <= 1'b0;
            fs2_d_r <= 1'b0;
            fs3_d_r <= 1'b0;
        end else begin
            data_r  <= ppi_data_i;
            fs1_r   <= ppi_fs1_i;
            fs2_r   <= ppi_fs2_i;
            fs3_r   <= ppi_fs3_i;
            fs1_d_r <= fs1_r;
            fs2_d_r <= fs2_r;
            fs3_d_r <= fs3_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:    if (arm_i)      state_next_s = ST_ARMED;   else state_next_s = ST_IDLE;
            ST_ARMED:   if (fs2_rise_s) state_next_s = ST_CAPTURE; else state_next_s = ST_ARMED;
            ST_CAPTURE: if (fs2_fall_s) state_next_s = ST_DONE;    else state_next_s = ST_CAPTURE;
            ST_DONE:    state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode; busy tracks the next state so the registered copy matches the state.
    always_comb begin
        busy_s = (state_next_s == ST_ARMED) | (state_next_s == ST_CAPTURE);
        done_s = (state_r == ST_DONE);
    end

    // Registered status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            busy_r       <= busy_s;
            frame_done_r <= done_s;
        end
    end

    // Frame statistics and write pointer; cleared on an accepted arm, held otherwise.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || arm_accept_s) begin
            pixel_count_r <= {CNT_BITS{1'b0}};
            line_count_r  <= {CNT_BITS{1'b0}};
            fs3_count_r   <= 8'd0;
            checksum_r    <= 16'd0;
            overflow_r    <= 1'b0;
            wr_ptr_r      <= {(ADDR_BITS+1){1'b0}};
        end else begin
            if (sample_s) begin
                checksum_r <= checksum_r + data_r;
                if (pixel_count_r != CNT_MAX) begin
                    pixel_count_r <= pixel_count_r + CNT_ONE;
                end
                if (full_s) begin
                    overflow_r <= 1'b1;
                end else begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
            end
            if (line_inc_s && (line_count_r != CNT_MAX)) begin
                line_count_r <= line_count_r + CNT_ONE;
            end
            if (fs3_inc_s && (fs3_count_r != 8'hFF)) begin
                fs3_count_r <= fs3_count_r + 8'd1;
            end
        end
    end

    // Pixel buffer: one write port, one registered read port with read-old-data behaviour.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[ADDR_BITS-1:0]] <= data_r;
        end
        rd_data_r <= mem_r[rd_addr_i];
    end

    assign busy_o        = busy_r;
    assign frame_done_o  = frame_done_r;
    assign pixel_count_o = pixel_count_r;
    assign line_count_o  = line_count_r;
    assign fs3_count_o   = fs3_count_r;
    assign checksum_o    = checksum_r;
    assign overflow_o    = overflow_r;
    assign rd_data_o     = rd_data_r;

endmodule

// File: tb/tb_ppi_frame_receiver.sv
// Directed bench for ppi_frame_receiver: a default-size instance and a 16-word
// instance share the PPI stimulus; the small one exercises buffer overflow.
module tb_ppi_frame_receiver;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [15:0] ppi_data_i;
    logic        ppi_fs1_i, ppi_fs2_i, ppi_fs3_i, arm_i;
    logic [9:0]  rd_addr;
    logic [3:0]  rd_addr_sm;

    logic        busy, frame_done, overflow;
    logic [15:0] pixel_count, line_count, checksum, rd_data;
    logic [7:0]  fs3_count;
    logic        sm_busy, sm_frame_done, sm_overflow;
    logic [15:0] sm_pixel_count, sm_line_count, sm_checksum, sm_rd_data;
    logic [7:0]  sm_fs3_count;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int lat;

    ppi_frame_receiver dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ppi_data_i(ppi_data_i),
        .ppi_fs1_i(ppi_fs1_i), .ppi_fs2_i(ppi_fs2_i), .ppi_fs3_i(ppi_fs3_i),
        .arm_i(arm_i), .busy_o(busy), .frame_done_o(frame_done),
        .pixel_count_o(pixel_count), .line_count_o(line_count),
        .fs3_count_o(fs3_count), .checksum_o(checksum), .overflow_o(overflow),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data)
    );

    ppi_frame_receiver #(.ADDR_BITS(4)) dut_sm (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ppi_data_i(ppi_data_i),
        .ppi_fs1_i(ppi_fs1_i), .ppi_fs2_i(ppi_fs2_i), .ppi_fs3_i(ppi_fs3_i),
        .arm_i(arm_i), .busy_o(sm_busy), .frame_done_o(sm_frame_done),
        .pixel_count_o(sm_pixel_count), .line_count_o(sm_line_count),
        .fs3_count_o(sm_fs3_count), .checksum_o(sm_checksum), .overflow_o(sm_overflow),
        .rd_addr_i(rd_addr_sm), .rd_data_o(sm_rd_data)
    );

    always #5 clk_i = ~clk_i;

    // Count frame_done pulses of the default instance mid-cycle.
    always @(negedge clk_i) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic send_line(input int n, input logic [15:0] base, input logic [15:0] incr);
        for (int i = 0; i < n; i++) begin
            ppi_fs1_i  = 1'b1;
            ppi_data_i = base + 16'(i) * incr;
            tick();
        end
        ppi_fs1_i  = 1'b0;
        ppi_data_i = 16'd0;
        tick();
        tick();
    endtask

    // Drops fs2 and measures cycles until frame_done, bounded.
    task automatic end_frame(input string tag);
        ppi_fs2_i = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (frame_done !== 1'b1 && lat < 20);
        chk({tag, "_latency"}, lat, 32'd3);
        tick();
        tick();
        tick();
        chk({tag, "_done_pulses"}, done_cnt, 32'd1);
        chk({tag, "_busy_after"}, busy, 32'd0);
    endtask

    task automatic rd(input logic [9:0] a);
        rd_addr    = a;
        rd_addr_sm = a[3:0];
        tick();
    endtask

    initial begin
        rst_n_i = 1'b0; ppi_data_i = 16'd0; ppi_fs1_i = 1'b0; ppi_fs2_i = 1'b0;
        ppi_fs3_i = 1'b0; arm_i = 1'b0; rd_addr = 10'd0; rd_addr_sm = 4'd0;
        tick(); tick();
        rst_n_i = 1'b1;
        tick();
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", frame_done, 32'd0);
        chk("rst_pix", pixel_count, 32'd0);
        chk("rst_line", line_count, 32'd0);
        chk("rst_cksum", checksum, 32'd0);
        chk("rst_ovf", overflow, 32'd0);

        // Nominal 4x8 frame, data 1..32, with two fs3 pulses inside the frame.
        arm();
        chk("nom_busy_armed", busy, 32'd1);
        done_cnt = 0;
        ppi_fs2_i = 1'b1; tick(); tick();
        for (int l = 0; l < 4; l++) begin
            ppi_fs3_i = (l < 2); tick(); ppi_fs3_i = 1'b0; tick();
            send_line(8, 16'(1 + 8 * l), 16'd1);
        end
        chk("nom_busy_capture", busy, 32'd1);
        end_frame("nom");
        chk("nom_pix", pixel_count, 32'd32);
        chk("nom_line", line_count, 32'd4);
        chk("nom_cksum", checksum, 32'h0210);
        chk("nom_fs3", fs3_count, 32'd2);
        chk("nom_ovf", overflow, 32'd0);
        rd(10'd5);
        chk("nom_rd5", rd_data, 32'd6);
        rd(10'd31);
        chk("nom_rd31", rd_data, 32'd32);
        chk("nom_hold_pix", pixel_count, 32'd32);

        // Arm while a frame is already running: that frame is skipped.
        done_cnt = 0;
        ppi_fs2_i = 1'b1; tick();
        ppi_fs1_i = 1'b1; ppi_data_i = 16'h0100; arm_i = 1'b1; tick(); arm_i = 1'b0;
        send_line(3, 16'h0101, 16'd1);
        chk("mid_busy_in_skip", busy, 32'd1);
        ppi_fs2_i = 1'b0; tick(); tick();
        chk("mid_busy_gap", busy, 32'd1);
        chk("mid_pix_skipped", pixel_count, 32'd0);
        chk("mid_no_done", done_cnt, 32'd0);
        ppi_fs2_i = 1'b1; tick(); tick();
        send_line(4, 16'd10, 16'd1);
        chk("mid_busy_capture", busy, 32'd1);
        end_frame("mid");
        chk("mid_pix", pixel_count, 32'd4);
        chk("mid_line", line_count, 32'd1);
        chk("mid_cksum", checksum, 32'd46);

        // Overflow: 20 pixels of 0xFFFF into a 16-word buffer.
        arm();
        done_cnt = 0;
        ppi_fs2_i = 1'b1; tick(); tick();
        send_line(20, 16'hFFFF, 16'd0);
        end_frame("ovf");
        chk("ovf_pix", sm_pixel_count, 32'd20);
        chk("ovf_flag", sm_overflow, 32'd1);
        chk("ovf_cksum", sm_checksum, 32'hFFEC);
        chk("ovf_big_flag", overflow, 32'd0);
        chk("ovf_big_pix", pixel_count, 32'd20);
        for (int a = 0; a < 16; a++) begin
            rd(10'(a));
            chk($sformatf("ovf_rd%0d", a), sm_rd_data, 32'hFFFF);
        end

        // Overflow with distinct tail data: no wrap onto address 0.
        arm();
        done_cnt = 0;
        ppi_fs2_i = 1'b1; tick(); tick();
        send_line(16, 16'hFFFF, 16'd0);
        send_line(4, 16'h1234, 16'd0);
        end_frame("wrap");
        chk("wrap_pix", sm_pixel_count, 32'd20);
        chk("wrap_line", sm_line_count, 32'd2);
        chk("wrap_ovf", sm_overflow, 32'd1);
        chk("wrap_cksum", sm_checksum, 32'h48C0);
        rd(10'd0);
        chk("wrap_rd0_sm", sm_rd_data, 32'hFFFF);
        chk("wrap_rd0_big", rd_data, 32'hFFFF);
        rd(10'd16);
        chk("wrap_rd16_big", rd_data, 32'h1234);

        // fs1 activity with fs2 low is ignored and leaves the FSM armed.
        arm();
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            ppi_fs1_i = 1'b1; ppi_data_i = 16'h0055; tick();
            ppi_fs1_i = 1'b0; tick();
        end
        tick(); tick();
        chk("out_pix", pixel_count, 32'd0);
        chk("out_line", line_count, 32'd0);
        chk("out_cksum", checksum, 32'd0);
        chk("out_busy", busy, 32'd1);

        // Reset after three captured pixels aborts the frame.
        ppi_fs2_i = 1'b1; tick(); tick();
        for (int i = 0; i < 3; i++) begin
            ppi_fs1_i = 1'b1; ppi_data_i = 16'(7 + i); tick();
        end
        ppi_fs1_i = 1'b0; tick(); tick();
        chk("rmc_pix_before", pixel_count, 32'd3);
        rst_n_i = 1'b0; tick(); rst_n_i = 1'b1;
        chk("rmc_busy", busy, 32'd0);
        chk("rmc_pix", pixel_count, 32'd0);
        chk("rmc_line", line_count, 32'd0);
        chk("rmc_cksum", checksum, 32'd0);
        chk("rmc_ovf", overflow, 32'd0);
        send_line(3, 16'd20, 16'd1);
        ppi_fs2_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rmc_no_done", done_cnt, 32'd0);
        chk("rmc_pix_unarmed", pixel_count, 32'd0);
        chk("rmc_busy_unarmed", busy, 32'd0);

        // fs2 and fs1 rise together; arm pulsed mid-capture is ignored.
        arm();
        done_cnt = 0;
        ppi_fs2_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ppi_fs1_i = 1'b1; ppi_data_i = 16'(5 + i); arm_i = (i == 2); tick();
        end
        arm_i = 1'b0; ppi_fs1_i = 1'b0; tick(); tick();
        end_frame("edge");
        chk("edge_pix", pixel_count, 32'd4);
        chk("edge_line", line_count, 32'd1);
        chk("edge_cksum", checksum, 32'd26);
        rd(10'd0);
        chk("edge_rd0", rd_data, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
